// File: rtl/renas_dma_master.sv
// ---------------------------------------------------------------------------
// renas_dma_master
//
// Purpose : AHB-lite bus master that copies a block of 32-bit words from a
//           source address to a destination address, one single NONSEQ read
//           followed by one single NONSEQ write per word. It sits beside the
//           CPU as a second master and tolerates slaves that stretch the data
//           phase with hreadyout=0 (bounded by TIMEOUT cycles).
//
// Ports   :
//   clk_l2       in   sole clock, posedge
//   rst_n        in   asynchronous active-low reset
//   start        in   one-cycle job request, sampled only in IDLE
//   src_addr     in   source byte address (bits [1:0] dropped on capture)
//   dst_addr     in   destination byte address (bits [1:0] dropped on capture)
//   len          in   number of words to copy
//   busy         out  job in progress
//   done         out  one-cycle pulse at job end (success or abort)
//   err          out  sticky error flag, cleared by the next accepted start
//   dma_hbusreq  out  bus request to the arbiter, high while busy
//   dma_hgrant   in   grant from the arbiter
//   dma_out      out  AHB master signals (haddr, hwdata, hwrite, htrans, hsize)
//   dma_in       in   AHB slave response (hreadyout, hrdata, hresp)
//   o_dbg_state  out  current FSM state, for observation only
// ---------------------------------------------------------------------------
package renas_dma_pkg;

    typedef struct packed {
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic        hwrite;
        logic [1:0]  htrans;
        logic [2:0]  hsize;
    } mas_send_type;

    typedef struct packed {
        logic        hreadyout;
        logic [31:0] hrdata;
        logic [1:0]  hresp;
    } slv_send_type;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_DATA = 3'd3,
        S_WR_ADDR = 3'd4,
        S_WR_DATA = 3'd5,
        S_FIN     = 3'd6
    } dma_state_e;

endpackage

module renas_dma_master
    import renas_dma_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_l2,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             dma_hbusreq,
    input  logic             dma_hgrant,
    output mas_send_type     dma_out,
    input  slv_send_type     dma_in,
    output logic [2:0]       o_dbg_state
);

    localparam int                TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    dma_state_e        r_state;
    dma_state_e        w_next;
    logic [31:0]       r_src;
    logic [31:0]       r_dst;
    logic [LEN_W-1:0]  r_cnt;
    logic [31:0]       r_buf;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_accept;
    logic              w_data_ph;
    logic              w_resp_ok;
    logic              w_resp_err;
    logic              w_tmo_hit;

    // Bus handshake: an address phase is issued only in a cycle where the
    // FSM is in an ADDR state AND dma_hgrant=1 (htrans=NONSEQ); otherwise
    // htrans stays IDLE and the FSM waits. The following data phase completes
    // on the first cycle with hreadyout=1, whatever the grant is doing;
    // hresp is only meaningful in that completing cycle. Any response other
    // than OKAY is treated as an error.

    assign w_accept = (r_state == S_IDLE) && start;

    // ---------------- state register ----------------
    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next     = r_state;
        w_data_ph  = (r_state == S_RD_DATA) || (r_state == S_WR_DATA);
        w_resp_ok  = w_data_ph && dma_in.hreadyout && (dma_in.hresp == HRESP_OKAY);
        w_resp_err = w_data_ph && dma_in.hreadyout && (dma_in.hresp != HRESP_OKAY);
        // Fires on the cycle whose wait would push the counter to TIMEOUT.
        w_tmo_hit  = w_data_ph && !dma_in.hreadyout && (r_tmo == TMO_LAST);

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (len == '0) ? S_FIN : S_REQ;
                end
            end
            S_REQ: begin
                if (dma_hgrant) begin
                    w_next = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                if (dma_hgrant) begin
                    w_next = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (w_resp_ok) begin
                    w_next = S_WR_ADDR;
                end else if (w_resp_err || w_tmo_hit) begin
                    w_next = S_FIN;
                end
            end
            S_WR_ADDR: begin
                if (dma_hgrant) begin
                    w_next = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (w_resp_ok) begin
                    w_next = (r_cnt == LEN_W'(1)) ? S_FIN : S_RD_ADDR;
                end else if (w_resp_err || w_tmo_hit) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------- datapath and status registers ----------------
    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_cnt  <= '0;
            r_buf  <= '0;
            r_tmo  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIN);

            if (w_accept) begin
                r_busy <= 1'b1;
                r_err  <= 1'b0;
                r_src  <= {src_addr[31:2], 2'b00};
                r_dst  <= {dst_addr[31:2], 2'b00};
                r_cnt  <= len;
            end else begin
                if (r_state == S_FIN) begin
                    r_busy <= 1'b0;
                end
                if (w_resp_err || w_tmo_hit) begin
                    r_err <= 1'b1;
                end
            end

            if ((r_state == S_RD_DATA) && w_resp_ok) begin
                r_buf <= dma_in.hrdata;
            end

            // Addresses advance only once the write has been accepted, so an
            // aborted word is never counted as copied. Wrap is plain modulo.
            if ((r_state == S_WR_DATA) && w_resp_ok) begin
                r_src <= r_src + 32'd4;
                r_dst <= r_dst + 32'd4;
                r_cnt <= r_cnt - LEN_W'(1);
            end

            // Clearing throughout the ADDR state equals clearing on entry to
            // the data phase, since every data phase is entered from one.
            if ((r_state == S_RD_ADDR) || (r_state == S_WR_ADDR)) begin
                r_tmo <= '0;
            end else if (w_data_ph && !dma_in.hreadyout) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
        end
    end

    // ---------------- bus outputs ----------------
    // haddr/hwrite/hwdata are held through the data phase because the slave
    // samples the address continuously, not only on NONSEQ.
    always_comb begin
        dma_out = '0;
        case (r_state)
            S_RD_ADDR: begin
                dma_out.haddr  = r_src;
                dma_out.hsize  = HSIZE_WORD;
                dma_out.htrans = dma_hgrant ? HTRANS_NONSEQ : HTRANS_IDLE;
            end
            S_RD_DATA: begin
                dma_out.haddr  = r_src;
                dma_out.hsize  = HSIZE_WORD;
            end
            S_WR_ADDR: begin
                dma_out.haddr  = r_dst;
                dma_out.hwdata = r_buf;
                dma_out.hwrite = 1'b1;
                dma_out.hsize  = HSIZE_WORD;
                dma_out.htrans = dma_hgrant ? HTRANS_NONSEQ : HTRANS_IDLE;
            end
            S_WR_DATA: begin
                dma_out.haddr  = r_dst;
                dma_out.hwdata = r_buf;
                dma_out.hwrite = 1'b1;
                dma_out.hsize  = HSIZE_WORD;
            end
            default: begin
                dma_out = '0;
            end
        endcase
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign dma_hbusreq = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_renas_dma_master.sv
// ---------------------------------------------------------------------------
// tb_renas_dma_master
//
// Directed bench for renas_dma_master: a behavioural AHB slave with a
// programmable data-phase latency, read-error injection and a stall mode,
// an address-phase monitor fed by an expected-transfer queue, and
// hand-computed cycle counts for each job.
// ---------------------------------------------------------------------------
module tb_renas_dma_master;
    import renas_dma_pkg::*;

    localparam int LEN_W = 16;
    localparam int TMO   = 16;

    // ---------------- clock / reset ----------------
    logic             clk_l2   = 1'b0;
    logic             rst_n    = 1'b0;
    logic             start    = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len      = '0;
    logic             dma_hgrant = 1'b0;
    logic             busy;
    logic             done;
    logic             err;
    logic             dma_hbusreq;
    mas_send_type     dma_out;
    slv_send_type     dma_in;
    logic [2:0]       dbg_state;

    always #5 clk_l2 = ~clk_l2;

    renas_dma_master #(
        .LEN_W   (LEN_W),
        .TIMEOUT (TMO)
    ) u_dut (
        .clk_l2      (clk_l2),
        .rst_n       (rst_n),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .dma_hbusreq (dma_hbusreq),
        .dma_hgrant  (dma_hgrant),
        .dma_out     (dma_out),
        .dma_in      (dma_in),
        .o_dbg_state (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          lat        = 3;
    bit          s_stall    = 1'b0;
    int          s_err_at   = -1;
    int          s_rd_total = 0;
    logic [31:0] rmem [256];
    logic [31:0] wmem [256];
    bit          wvalid [256];
    logic        s_pend;
    logic        s_write;
    logic        s_err;
    int          s_wait;
    logic [31:0] s_addr;
    logic [31:0] s_rdata;

    always @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            s_pend  <= 1'b0;
            s_write <= 1'b0;
            s_err   <= 1'b0;
            s_wait  <= 0;
            s_addr  <= '0;
            s_rdata <= '0;
        end else begin
            if (s_pend && (s_wait == 0) && !s_stall) begin
                s_pend <= 1'b0;
                if (s_write && !s_err) begin
                    wmem[s_addr[9:2]]   <= dma_out.hwdata;
                    wvalid[s_addr[9:2]] <= 1'b1;
                end
            end else if (s_pend && (s_wait > 0)) begin
                s_wait <= s_wait - 1;
            end
            if (dma_out.htrans == 2'b10) begin
                s_pend  <= 1'b1;
                s_wait  <= lat - 1;
                s_write <= dma_out.hwrite;
                s_addr  <= dma_out.haddr;
                s_rdata <= rmem[dma_out.haddr[9:2]];
                s_err   <= !dma_out.hwrite && (s_rd_total == s_err_at);
                if (!dma_out.hwrite) s_rd_total <= s_rd_total + 1;
            end
        end
    end

    always_comb begin
        dma_in           = '0;
        dma_in.hreadyout = s_stall ? 1'b0 : (s_pend ? (s_wait == 0) : 1'b1);
        dma_in.hrdata    = s_rdata;
        dma_in.hresp     = (s_pend && s_err) ? 2'b01 : 2'b00;
    end

    // ---------------- scoreboard: address phases ----------------
    logic [32:0] exp_q[$];
    int          n_nonseq = 0;
    int          n_unexp  = 0;

    always @(negedge clk_l2) begin
        if (rst_n && (dma_out.htrans == 2'b10)) begin
            n_nonseq++;
            check("hsize", 64'(dma_out.hsize), 64'(3'b010));
            if (exp_q.size() == 0) n_unexp++;
            else check("xfer", 64'({dma_out.hwrite, dma_out.haddr}), 64'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a posedge (cycle 0); returns just after the next one.
    task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] l);
        src_addr = s;
        dst_addr = d;
        len      = l;
        start    = 1'b1;
        @(posedge clk_l2); #1;
        start    = 1'b0;
    endtask

    // Steps cycles 1..max after the start cycle, optionally raising grant and
    // pulsing start at given cycles, until done is seen.
    task automatic run_wait(input int max_cyc, input int grant_at, input int start_a, input int start_b,
                            output int done_cyc, output int busy_cyc, output int rdd_cyc,
                            output logic err_at_done);
        done_cyc    = 0;
        busy_cyc    = 0;
        rdd_cyc     = 0;
        err_at_done = 1'b0;
        for (int n = 1; (n <= max_cyc) && (done_cyc == 0); n++) begin
            if (n == grant_at) dma_hgrant = 1'b1;
            start = (n == start_a) || (n == start_b);
            @(negedge clk_l2);
            if (busy) busy_cyc++;
            if (dbg_state == 3'd3) rdd_cyc++;
            if (done) begin
                done_cyc    = n;
                err_at_done = err;
            end
            @(posedge clk_l2); #1;
        end
        start = 1'b0;
        check("done_seen", 64'(done_cyc != 0), 64'(1));
    endtask

    task automatic push_xfer(input logic wr, input logic [31:0] a);
        exp_q.push_back({wr, a});
    endtask

    // ---------------- stimulus ----------------
    int   dc, bc, rc, nb;
    logic ed;

    initial begin
        for (int i = 0; i < 256; i++) rmem[i] = 32'h5555_0000 + i;

        // reset values
        repeat (2) @(posedge clk_l2);
        @(negedge clk_l2);
        check("rst_busy",   64'(busy), 64'(0));
        check("rst_done",   64'(done), 64'(0));
        check("rst_err",    64'(err), 64'(0));
        check("rst_busreq", 64'(dma_hbusreq), 64'(0));
        check("rst_haddr",  64'(dma_out.haddr), 64'(0));
        check("rst_hwdata", 64'(dma_out.hwdata), 64'(0));
        check("rst_ctrl",   64'({dma_out.hwrite, dma_out.htrans, dma_out.hsize}), 64'(0));
        check("rst_state",  64'(dbg_state), 64'(0));
        rst_n = 1'b1;
        @(posedge clk_l2); #1;

        // job 1: 4 words, 3-cycle latency, 0x0 -> 0x100
        lat = 3;
        dma_hgrant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rmem[i] = 32'hA0 + i;
            push_xfer(1'b0, 32'(4 * i));
            push_xfer(1'b1, 32'h100 + 32'(4 * i));
        end
        nb = n_nonseq;
        start_job(32'h0, 32'h100, 16'd4);
        run_wait(200, 0, 0, 0, dc, bc, rc, ed);
        check("j1_done_cyc", 64'(dc), 64'(35));
        check("j1_busy_cyc", 64'(bc), 64'(34));
        check("j1_rdd_cyc",  64'(rc), 64'(12));
        check("j1_err",      64'(ed), 64'(0));
        @(negedge clk_l2);
        check("j1_done_once", 64'(done), 64'(0));
        check("j1_nonseq", 64'(n_nonseq - nb), 64'(8));
        for (int i = 0; i < 4; i++) check("j1_dst", 64'(wmem[64 + i]), 64'(32'hA0 + i));
        @(posedge clk_l2); #1;

        // job 2: best case, 1-cycle latency, 2 words, 0x10 (unaligned 0x13) -> 0x180
        lat = 1;
        for (int i = 0; i < 2; i++) begin
            rmem[4 + i] = 32'hC0 + i;
            push_xfer(1'b0, 32'h10 + 32'(4 * i));
            push_xfer(1'b1, 32'h180 + 32'(4 * i));
        end
        start_job(32'h13, 32'h182, 16'd2);
        run_wait(100, 0, 0, 0, dc, bc, rc, ed);
        check("j2_done_cyc", 64'(dc), 64'(11));
        check("j2_busy_cyc", 64'(bc), 64'(10));
        check("j2_rdd_cyc",  64'(rc), 64'(2));
        check("j2_dst0", 64'(wmem[96]), 64'(32'hC0));
        check("j2_dst1", 64'(wmem[97]), 64'(32'hC1));

        // job 3: len=0
        nb = n_nonseq;
        start_job(32'h0, 32'h0, 16'd0);
        run_wait(20, 0, 0, 0, dc, bc, rc, ed);
        check("j3_done_cyc", 64'(dc), 64'(2));
        check("j3_busy_cyc", 64'(bc), 64'(1));
        check("j3_nonseq",   64'(n_nonseq - nb), 64'(0));

        // job 4: error on second read of a 4-word job
        lat = 3;
        for (int i = 0; i < 4; i++) rmem[16 + i] = 32'hB0 + i;
        s_err_at = s_rd_total + 1;
        push_xfer(1'b0, 32'h40);
        push_xfer(1'b1, 32'h200);
        push_xfer(1'b0, 32'h44);
        start_job(32'h40, 32'h200, 16'd4);
        run_wait(100, 0, 0, 0, dc, bc, rc, ed);
        check("j4_done_cyc", 64'(dc), 64'(15));
        check("j4_err",      64'(ed), 64'(1));
        check("j4_w0_data",  64'(wmem[128]), 64'(32'hB0));
        check("j4_w1_none",  64'(wvalid[129]), 64'(0));
        @(negedge clk_l2);
        check("j4_htrans_idle", 64'(dma_out.htrans), 64'(0));
        check("j4_busy_low",    64'(busy), 64'(0));
        check("j4_err_sticky",  64'(err), 64'(1));
        @(posedge clk_l2); #1;
        s_err_at = -1;
        start_job(32'h0, 32'h0, 16'd0);
        @(negedge clk_l2);
        check("j4_err_cleared", 64'(err), 64'(0));
        @(posedge clk_l2); #1;
        repeat (3) @(posedge clk_l2); #1;

        // job 5: slave never ready -> timeout after 16 data cycles
        s_stall = 1'b1;
        push_xfer(1'b0, 32'h0);
        start_job(32'h0, 32'h300, 16'd1);
        run_wait(100, 0, 0, 0, dc, bc, rc, ed);
        check("j5_rdd_cyc",  64'(rc), 64'(16));
        check("j5_done_cyc", 64'(dc), 64'(20));
        check("j5_err",      64'(ed), 64'(1));
        s_stall = 1'b0;
        repeat (3) @(posedge clk_l2); #1;

        // job 6: grant low for 5 cycles, extra starts mid-job and at FIN
        lat = 1;
        dma_hgrant = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rmem[8 + i] = 32'hD0 + i;
            push_xfer(1'b0, 32'h20 + 32'(4 * i));
            push_xfer(1'b1, 32'h280 + 32'(4 * i));
        end
        nb = n_nonseq;
        start_job(32'h20, 32'h280, 16'd2);
        run_wait(100, 6, 10, 15, dc, bc, rc, ed);
        check("j6_done_cyc", 64'(dc), 64'(16));
        check("j6_busy_cyc", 64'(bc), 64'(15));
        check("j6_err",      64'(ed), 64'(0));
        @(negedge clk_l2);
        check("j6_fin_start_ignored", 64'(busy), 64'(0));
        repeat (4) @(negedge clk_l2);
        check("j6_nonseq", 64'(n_nonseq - nb), 64'(4));
        check("j6_dst0", 64'(wmem[160]), 64'(32'hD0));
        check("j6_dst1", 64'(wmem[161]), 64'(32'hD1));
        @(posedge clk_l2); #1;

        // job 7: source address wraps past 0xFFFF_FFFC
        rmem[254] = 32'hE0;
        rmem[255] = 32'hE1;
        rmem[0]   = 32'hE2;
        push_xfer(1'b0, 32'hFFFF_FFF8);
        push_xfer(1'b1, 32'h80);
        push_xfer(1'b0, 32'hFFFF_FFFC);
        push_xfer(1'b1, 32'h84);
        push_xfer(1'b0, 32'h0);
        push_xfer(1'b1, 32'h88);
        start_job(32'hFFFF_FFF8, 32'h80, 16'd3);
        run_wait(100, 0, 0, 0, dc, bc, rc, ed);
        check("j7_done_cyc", 64'(dc), 64'(15));
        check("j7_err",      64'(ed), 64'(0));
        for (int i = 0; i < 3; i++) check("j7_dst", 64'(wmem[32 + i]), 64'(32'hE0 + i));

        // job 8: reset asserted mid-job, in the second word's read address phase
        push_xfer(1'b0, 32'hFFFF_FFF8);
        push_xfer(1'b1, 32'h90);
        start_job(32'hFFFF_FFF8, 32'h90, 16'd3);
        repeat (5) @(posedge clk_l2);
        #1;
        check("j8_pre_state", 64'(dbg_state), 64'(3'd2));
        rst_n = 1'b0;
        #1;
        check("j8_busy",   64'(busy), 64'(0));
        check("j8_busreq", 64'(dma_hbusreq), 64'(0));
        check("j8_htrans", 64'(dma_out.htrans), 64'(0));
        check("j8_haddr",  64'(dma_out.haddr), 64'(0));
        check("j8_hwdata", 64'(dma_out.hwdata), 64'(0));
        check("j8_state",  64'(dbg_state), 64'(0));
        nb = n_nonseq;
        repeat (2) @(posedge clk_l2);
        @(negedge clk_l2);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_l2);
        check("j8_quiet_nonseq", 64'(n_nonseq - nb), 64'(0));
        check("j8_quiet_busy",   64'(busy), 64'(0));
        check("j8_w0_data", 64'(wmem[36]), 64'(32'hE0));
        check("j8_w1_none", 64'(wvalid[37]), 64'(0));

        // scoreboard must be drained with nothing unexpected
        check("exp_q_empty", 64'(exp_q.size()), 64'(0));
        check("unexpected_xfers", 64'(n_unexp), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
